// File: rtl/ltc2324_pkg.sv
// Shared types and default timing for the LTC2324 conversion/readout sequencer.
package ltc2324_pkg;

    localparam int PERIOD_CYC_DEF   = 64;
    localparam int CNV_HIGH_CYC_DEF = 3;
    localparam int CONV_CYC_DEF     = 40;
    localparam int NBITS_DEF        = 16;
    localparam int TMR_W            = 16;
    localparam int CNT_W            = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNV,
        ST_CONV,
        ST_SHIFT,
        ST_LATCH,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/ltc2324_cnv_ctrl_cyc_timer.sv
// Loadable down-counter with a zero flag; times the CNV, CONV and SHIFT phases.
module ltc2324_cnv_ctrl_cyc_timer
    import ltc2324_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ltc2324_cnv_ctrl.sv
// LTC2324 CNV/SCK sequencer: issues CNV, waits out conversion, gates a 16-bit SCK
// burst and strobes the downstream deserializer. Free-running or triggered.
module ltc2324_cnv_ctrl
    import ltc2324_pkg::*;
#(
    parameter int PERIOD_CYC   = PERIOD_CYC_DEF,
    parameter int CNV_HIGH_CYC = CNV_HIGH_CYC_DEF,
    parameter int CONV_CYC     = CONV_CYC_DEF,
    parameter int NBITS        = NBITS_DEF
) (
    input  logic             clk_sdr,
    input  logic             reset,
    input  logic             enable,
    input  logic             free_run,
    input  logic             trig,
    input  logic [3:0]       channel_id,
    input  logic             clr_ovr,
    output logic             cnv,
    output logic             sck_en,
    output logic             rx_start,
    output logic             data_latch,
    output logic [3:0]       channel,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [TMR_W-1:0] CNV_LOAD    = TMR_W'(CNV_HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] CONV_LOAD   = TMR_W'(CONV_CYC - 1);
    localparam logic [TMR_W-1:0] SHIFT_LOAD  = TMR_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

    state_e           state_q, state_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             start;
    logic             period_done;

    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [3:0]       channel_q, channel_d;
    logic             cnv_q, cnv_d;
    logic             sck_en_q, sck_en_d;
    logic             rx_start_q, rx_start_d;
    logic             data_latch_q, data_latch_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;

    // In SHIFT the timer count is the bit index, NBITS-1 down to 0.
    ltc2324_cnv_ctrl_cyc_timer u_timer (
        .clk      (clk_sdr),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign period_done = (period_cnt_q >= PERIOD_LAST);

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (free_run || trig)) start = 1'b1;
            end
            ST_CNV: begin
                if (tmr_zero) begin
                    state_d  = ST_CONV;
                    tmr_load = 1'b1;
                    tmr_val  = CONV_LOAD;
                end
            end
            ST_CONV: begin
                if (tmr_zero) begin
                    state_d  = ST_SHIFT;
                    tmr_load = 1'b1;
                    tmr_val  = SHIFT_LOAD;
                end
            end
            ST_SHIFT: begin
                if (tmr_zero) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // A period already used up by the frame skips HOLD entirely.
                if (!free_run) begin
                    state_d = ST_IDLE;
                end else if (period_done) begin
                    if (enable) start = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (period_done) begin
                    if (enable && free_run) start = 1'b1;
                    else                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d  = ST_CNV;
            tmr_load = 1'b1;
            tmr_val  = CNV_LOAD;
        end
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        period_cnt_d = period_cnt_q;
        if (start) begin
            period_cnt_d = '0;
        end else if (period_cnt_q != '1) begin
            period_cnt_d = period_cnt_q + 1'b1;
        end

        channel_d    = start ? channel_id : channel_q;
        cnv_d        = (state_d == ST_CNV);
        sck_en_d     = (state_d == ST_SHIFT);
        rx_start_d   = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
        data_latch_d = (state_d == ST_LATCH);
        busy_d       = (state_d != ST_IDLE);
        sample_cnt_d = (state_d == ST_LATCH) ? sample_cnt_q + 1'b1 : sample_cnt_q;

        overrun_d = overrun_q;
        if (trig && enable && !free_run && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sdr) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            sample_cnt_q <= '0;
            channel_q    <= '0;
            cnv_q        <= 1'b0;
            sck_en_q     <= 1'b0;
            rx_start_q   <= 1'b0;
            data_latch_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            channel_q    <= channel_d;
            cnv_q        <= cnv_d;
            sck_en_q     <= sck_en_d;
            rx_start_q   <= rx_start_d;
            data_latch_q <= data_latch_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign cnv        = cnv_q;
    assign sck_en     = sck_en_q;
    assign rx_start   = rx_start_q;
    assign data_latch = data_latch_q;
    assign channel    = channel_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_ltc2324_cnv_ctrl.sv
// Directed bench for ltc2324_cnv_ctrl: default-timing instance plus a short-period instance.
module tb_ltc2324_cnv_ctrl;

    logic        clk_sdr = 1'b0;
    logic        reset;
    logic        enable;
    logic        free_run;
    logic        trig;
    logic [3:0]  channel_id;
    logic        clr_ovr;

    logic        cnv, sck_en, rx_start, data_latch, busy, overrun;
    logic [3:0]  channel;
    logic [15:0] sample_cnt;

    logic        s_cnv, s_sck_en, s_rx_start, s_data_latch, s_busy, s_overrun;
    logic [3:0]  s_channel;
    logic [15:0] s_sample_cnt;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int sck_tot = 0;
    int nlatch = 0;
    int rise_q[$];
    int srise_q[$];
    logic cnv_prev = 1'b0;
    logic s_cnv_prev = 1'b0;

    always #5 clk_sdr = ~clk_sdr;

    ltc2324_cnv_ctrl dut (
        .clk_sdr    (clk_sdr),
        .reset      (reset),
        .enable     (enable),
        .free_run   (free_run),
        .trig       (trig),
        .channel_id (channel_id),
        .clr_ovr    (clr_ovr),
        .cnv        (cnv),
        .sck_en     (sck_en),
        .rx_start   (rx_start),
        .data_latch (data_latch),
        .channel    (channel),
        .busy       (busy),
        .overrun    (overrun),
        .sample_cnt (sample_cnt)
    );

    ltc2324_cnv_ctrl #(.PERIOD_CYC(40)) dut_s (
        .clk_sdr    (clk_sdr),
        .reset      (reset),
        .enable     (enable),
        .free_run   (free_run),
        .trig       (trig),
        .channel_id (channel_id),
        .clr_ovr    (clr_ovr),
        .cnv        (s_cnv),
        .sck_en     (s_sck_en),
        .rx_start   (s_rx_start),
        .data_latch (s_data_latch),
        .channel    (s_channel),
        .busy       (s_busy),
        .overrun    (s_overrun),
        .sample_cnt (s_sample_cnt)
    );

    task automatic tick();
        @(negedge clk_sdr);
        cyc++;
        if (cnv && !cnv_prev) rise_q.push_back(cyc);
        if (s_cnv && !s_cnv_prev) srise_q.push_back(cyc);
        cnv_prev = cnv;
        s_cnv_prev = s_cnv;
        if (sck_en) sck_tot++;
        if (data_latch) nlatch++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_latch(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            tick();
            if (data_latch) ok = 1'b1;
        end
    endtask

    initial begin
        int t0;
        int n0;
        int guard;
        bit ok;

        reset = 1'b1; enable = 1'b0; free_run = 1'b0; trig = 1'b0;
        channel_id = 4'h0; clr_ovr = 1'b0;

        // 1: reset, then free-run start the cycle after release
        repeat (5) tick();
        chk("rst_outputs", {cnv, sck_en, rx_start, data_latch, busy, overrun, channel, sample_cnt}, 32'h0);
        enable = 1'b1; free_run = 1'b1; channel_id = 4'h5; reset = 1'b0;
        tick();
        t0 = cyc;
        chk("first_cnv", {cnv, busy}, 32'h3);
        channel_id = 4'hA;
        repeat (2) tick();
        chk("cnv_last_high", cnv, 1);
        tick();
        chk("cnv_fall", cnv, 0);
        repeat (39) tick();
        chk("rx_start_early", rx_start, 0);
        tick();
        chk("rx_start_t43", {rx_start, sck_en}, 32'h3);
        repeat (15) tick();
        chk("sck_last_t58", {rx_start, sck_en, data_latch}, 32'h2);
        tick();
        chk("latch_t59", {data_latch, sck_en}, 32'h2);
        chk("channel_f1", channel, 4'h5);
        chk("sample_cnt_f1", sample_cnt, 1);

        // 2: free-run period and SCK burst length
        guard = 0;
        while (rise_q.size() < 4 && guard < 400) begin tick(); guard++; end
        chk("four_rises", rise_q.size(), 4);
        if (rise_q.size() >= 4) begin
            chk("period_1", rise_q[1] - rise_q[0], 64);
            chk("period_2", rise_q[2] - rise_q[1], 64);
            chk("period_3", rise_q[3] - rise_q[2], 64);
        end
        wait_latch(100, ok);
        chk("latch_f4_seen", ok, 1);
        chk("sample_cnt_f4", sample_cnt, 4);
        chk("sck_total_f4", sck_tot, 64);
        chk("channel_recapture", channel, 4'hA);

        // 3: trigger mode and overrun
        free_run = 1'b0;
        repeat (3) tick();
        chk("idle_after_fr_off", busy, 0);
        trig = 1'b1; tick(); trig = 1'b0;
        t0 = cyc;
        chk("trig_cnv", {cnv, overrun}, 32'h2);
        repeat (19) tick();
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        chk("overrun_set", overrun, 1);
        wait_latch(60, ok);
        chk("trig_latch_seen", ok, 1);
        chk("trig_latch_t59", cyc - t0, 59);
        chk("sample_cnt_trig", sample_cnt, 5);
        repeat (3) tick();
        chk("trig_idle", busy, 0);
        n0 = rise_q.size();
        repeat (80) tick();
        chk("no_extra_frame", rise_q.size(), n0);
        chk("overrun_sticky", overrun, 1);
        trig = 1'b1; tick(); trig = 1'b0;
        tick();
        trig = 1'b1; clr_ovr = 1'b1; tick(); trig = 1'b0; clr_ovr = 1'b0;
        chk("set_beats_clear", overrun, 1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // 4: reset during the 8th SCK cycle
        guard = 0;
        while (!sck_en && guard < 60) begin tick(); guard++; end
        chk("sck_seen", sck_en, 1);
        repeat (7) tick();
        chk("sck_8th", sck_en, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midframe_rst", {cnv, sck_en, rx_start, data_latch, busy, overrun, channel, sample_cnt}, 32'h0);
        n0 = nlatch;
        repeat (30) tick();
        chk("no_latch_after_rst", nlatch, n0);

        // 5: enable dropped during CONV, busy trig while disabled
        channel_id = 4'h3; trig = 1'b1; tick(); trig = 1'b0;
        t0 = cyc;
        chk("f5_cnv", cnv, 1);
        repeat (5) tick();
        enable = 1'b0;
        tick();
        trig = 1'b1; tick(); trig = 1'b0;
        chk("no_ovr_when_disabled", overrun, 0);
        wait_latch(70, ok);
        chk("dis_latch_seen", ok, 1);
        chk("dis_latch_t59", cyc - t0, 59);
        chk("dis_sample_cnt", sample_cnt, 1);
        n0 = rise_q.size();
        repeat (80) tick();
        chk("dis_no_cnv", rise_q.size(), n0);
        chk("dis_idle", busy, 0);

        // 6: short period stretches to frame length, then counter wrap
        n0 = srise_q.size();
        enable = 1'b1; free_run = 1'b1;
        guard = 0;
        while (srise_q.size() < n0 + 3 && guard < 400) begin tick(); guard++; end
        chk("short_rises", srise_q.size(), n0 + 3);
        if (srise_q.size() >= n0 + 3) begin
            chk("short_period_1", srise_q[n0 + 1] - srise_q[n0], 60);
            chk("short_period_2", srise_q[n0 + 2] - srise_q[n0 + 1], 60);
        end
        free_run = 1'b0;
        repeat (150) tick();
        chk("both_idle", {busy, s_busy}, 32'h0);
        force dut.sample_cnt_d = 16'hFFFF;
        tick();
        release dut.sample_cnt_d;
        tick();
        chk("preload_ffff", sample_cnt, 16'hFFFF);
        trig = 1'b1; tick(); trig = 1'b0;
        wait_latch(70, ok);
        chk("wrap_latch_seen", ok, 1);
        chk("sample_cnt_wrap", sample_cnt, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
